// File: rtl/uart_loader_if.sv
// Memory write port driven by the UART loader: assembled word, byte address, strobe.
interface uart_loader_if;
  logic [31:0] data_out;
  logic [31:0] addr_out;
  logic        we;

  modport master (output data_out, output addr_out, output we);
  modport slave  (input  data_out, input  addr_out, input  we);
endinterface

// File: rtl/uart_loader.sv
// 8N1 UART receiver feeding a little-endian word assembler that writes a length-prefixed
// image into CPU memory and raises done once the announced word count has been stored.
module uart_loader #(
  parameter int          CLK_FREQ  = 100000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  uart_loader_if.master wr,
  output logic          done,
  output logic          frame_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic [1:0] {W_HDR, W_BODY, W_DONE} word_state_t;

  logic             r_rx_meta;
  logic             r_rx_s;
  byte_state_t      r_bstate;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_byte_valid;
  logic             r_frame_err;

  word_state_t      r_wstate;
  logic [1:0]       r_b;
  logic [23:0]      r_word;
  logic [31:0]      r_len;
  logic [31:0]      r_k;
  logic [31:0]      r_data_out;
  logic [31:0]      r_addr_out;
  logic             r_we;
  logic             r_done;
  logic [31:0]      w_word;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bstate     <= B_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      case (r_bstate)
        B_IDLE: begin
          if (!r_rx_s) begin
            r_bstate <= B_START;
            r_cnt    <= '0;
          end
        end
        B_START: begin
          // Mid-bit recheck rejects short low glitches on an idle line.
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_bstate <= r_rx_s ? B_IDLE : B_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        B_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit == 3'd7) r_bstate <= B_STOP;
            else               r_bit    <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        B_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_bstate <= B_IDLE;
            if (r_rx_s) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_bstate <= B_IDLE;
      endcase
    end
  end

  // Bytes 0..2 sit in r_word; the incoming byte completes the word on the 4th strobe.
  assign w_word = {r_byte, r_word};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate   <= W_HDR;
      r_b        <= '0;
      r_word     <= '0;
      r_len      <= '0;
      r_k        <= '0;
      r_data_out <= '0;
      r_addr_out <= ADDR_BASE;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_wstate)
        W_HDR: begin
          if (r_byte_valid) begin
            r_word <= {r_byte, r_word[23:8]};
            if (r_b == 2'd3) begin
              r_b   <= '0;
              r_len <= w_word;
              r_k   <= '0;
              if (w_word == 32'd0) begin
                r_wstate <= W_DONE;
                r_done   <= 1'b1;
              end else begin
                r_wstate <= W_BODY;
              end
            end else begin
              r_b <= r_b + 2'd1;
            end
          end
        end
        W_BODY: begin
          if (r_byte_valid) begin
            r_word <= {r_byte, r_word[23:8]};
            if (r_b == 2'd3) begin
              r_b        <= '0;
              r_data_out <= w_word;
              r_addr_out <= ADDR_BASE + (r_k << 2);
              r_we       <= 1'b1;
              r_k        <= r_k + 32'd1;
              if (r_k + 32'd1 == r_len) r_wstate <= W_DONE;
            end else begin
              r_b <= r_b + 2'd1;
            end
          end
        end
        W_DONE:  r_done   <= 1'b1;
        default: r_wstate <= W_HDR;
      endcase
    end
  end

  assign wr.data_out = r_data_out;
  assign wr.addr_out = r_addr_out;
  assign wr.we       = r_we;
  assign done        = r_done;
  assign frame_err   = r_frame_err;

endmodule
